// File: rtl/sheet_pkg.sv
// Shared definitions for the sheet-music sequencer: FSM state encoding and
// default sizing constants for the full-size instrument build.
package sheet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAST  = 2'd3
  } state_t;

  localparam int DEFAULT_KEYS        = 63;
  localparam int DEFAULT_DEPTH       = 1296;
  localparam int DEFAULT_TICK_PERIOD = 8333332;
  localparam int DEFAULT_BEATS       = 6;
  localparam int DEFAULT_FPB         = 2;

endpackage

// File: rtl/tempo_tick.sv
// Tempo divider: counts clock cycles while running and emits a one-cycle
// tick enable every TICK_PERIOD counted cycles. The count is held while not
// running and can be cleared back to zero.
module tempo_tick
  import sheet_pkg::*;
#(
  parameter int TICK_PERIOD = DEFAULT_TICK_PERIOD
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_PERIOD);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_PERIOD - 1);

  logic [CW-1:0] cnt;

  // Cycle counter: clear wins, otherwise advance and wrap only while running
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  // A held count sitting at the terminal value must not fire a tick
  assign tick = run && (cnt == CNT_MAX);

endmodule

// File: rtl/sheet_sequencer.sv
// Sheet-music sequencer: steps through a loadable frame memory of key-hold
// vectors at a programmable tempo, driving the key bus and the beat LEDs.
// Supports play/pause/stop, loop or one-shot playback and frame loading
// while idle.
module sheet_sequencer
  import sheet_pkg::*;
#(
  parameter int KEYS        = DEFAULT_KEYS,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int TICK_PERIOD = DEFAULT_TICK_PERIOD,
  parameter int BEATS       = DEFAULT_BEATS,
  parameter int FPB         = DEFAULT_FPB,
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             cmd_play,
  input  logic             cmd_pause,
  input  logic             cmd_stop,
  input  logic             loop_en,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [KEYS-1:0]  wr_data,
  output logic [KEYS-1:0]  sheet_hold,
  output logic [BEATS-1:0] beat_display,
  output logic [AW-1:0]    frame_idx,
  output logic             busy,
  output logic             done
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW = (FPB > 1) ? $clog2(FPB) : 1;

  localparam logic [AW-1:0]    LAST_IDX     = AW'(DEPTH - 1);
  localparam logic [AW:0]      DEPTH_LIM    = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0]    BEAT_MAX     = BW'(BEATS - 1);
  localparam logic [SW-1:0]    SUB_MAX      = SW'(FPB - 1);
  localparam logic [BEATS-1:0] BEAT0_ONEHOT = BEATS'(1) << (BEATS - 1);

  state_t state, next_state;

  logic [KEYS-1:0] mem [DEPTH];
  logic [KEYS-1:0] rd_data;
  logic [BW-1:0]   beat;
  logic [SW-1:0]   sub;

  logic tick;
  logic tick_run;
  logic tick_clear;
  logic step;
  logic finish;
  logic go_idle;

  // Tempo runs in PLAY (a pause request freezes it that same cycle) and LAST
  assign tick_run   = ((state == ST_PLAY) && !cmd_pause) || (state == ST_LAST);
  assign tick_clear = (state == ST_IDLE);

  tempo_tick #(
    .TICK_PERIOD(TICK_PERIOD)
  ) u_tempo_tick (
    .clk_100mhz(clk_100mhz),
    .rst_n     (rst_n),
    .run       (tick_run),
    .clear     (tick_clear),
    .tick      (tick)
  );

  assign step    = (state == ST_PLAY) && tick && !cmd_stop;
  assign finish  = (state == ST_LAST) && tick && !cmd_stop;
  assign go_idle = (state != ST_IDLE) && (next_state == ST_IDLE);
  assign busy    = (state != ST_IDLE);

  // Frame memory: writes only while idle, registered read of the next frame
  always_ff @(posedge clk_100mhz) begin
    if (wr_en && (state == ST_IDLE) && ({1'b0, wr_addr} < DEPTH_LIM)) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[frame_idx];
  end

  // Playback state register
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic with stop > pause > play priority
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_play && !cmd_stop) next_state = ST_PLAY;
      end
      ST_PLAY: begin
        if (cmd_stop) begin
          next_state = ST_IDLE;
        end else if (cmd_pause) begin
          next_state = ST_PAUSE;
        end else if (tick && (frame_idx == LAST_IDX) && !loop_en) begin
          next_state = ST_LAST;
        end
      end
      ST_PAUSE: begin
        if (cmd_stop) begin
          next_state = ST_IDLE;
        end else if (!cmd_pause && cmd_play) begin
          next_state = ST_PLAY;
        end
      end
      ST_LAST: begin
        if (cmd_stop || tick) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output registers, frame pointer and beat/sub-beat counters
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sheet_hold   <= '0;
      beat_display <= '0;
      frame_idx    <= '0;
      beat         <= '0;
      sub          <= '0;
      done         <= 1'b0;
    end else begin
      done <= finish;
      if (go_idle) begin
        sheet_hold   <= '0;
        beat_display <= '0;
        frame_idx    <= '0;
        beat         <= '0;
        sub          <= '0;
      end else if (step) begin
        sheet_hold <= rd_data;
        if (sub == '0) begin
          beat_display <= BEAT0_ONEHOT >> beat;
        end
        if ((frame_idx == LAST_IDX) && loop_en) begin
          frame_idx <= '0;
          beat      <= '0;
          sub       <= '0;
        end else begin
          if (frame_idx != LAST_IDX) begin
            frame_idx <= frame_idx + 1'b1;
          end
          if (sub == SUB_MAX) begin
            sub  <= '0;
            beat <= (beat == BEAT_MAX) ? '0 : beat + 1'b1;
          end else begin
            sub <= sub + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sheet_sequencer.sv
// Self-checking bench for sheet_sequencer: directed playback scenarios plus
// random command traffic, all compared cycle by cycle against a behavioural
// model that tracks elapsed tempo cycles and frame position arithmetically.
module tb_sheet_sequencer;

  localparam int KEYS  = 8;
  localparam int DEPTH = 4;
  localparam int TP    = 4;
  localparam int BEATS = 3;
  localparam int FPB   = 2;
  localparam int AW    = 2;
  localparam int W     = KEYS + BEATS + AW + 2;

  logic             clk_100mhz = 1'b0;
  logic             rst_n      = 1'b0;
  logic             cmd_play   = 1'b0;
  logic             cmd_pause  = 1'b0;
  logic             cmd_stop   = 1'b0;
  logic             loop_en    = 1'b0;
  logic             wr_en      = 1'b0;
  logic [AW-1:0]    wr_addr    = '0;
  logic [KEYS-1:0]  wr_data    = '0;
  logic [KEYS-1:0]  sheet_hold;
  logic [BEATS-1:0] beat_display;
  logic [AW-1:0]    frame_idx;
  logic             busy;
  logic             done;

  int n_vec = 0;
  int n_bad = 0;

  sheet_sequencer #(
    .KEYS       (KEYS),
    .DEPTH      (DEPTH),
    .TICK_PERIOD(TP),
    .BEATS      (BEATS),
    .FPB        (FPB)
  ) dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .cmd_play    (cmd_play),
    .cmd_pause   (cmd_pause),
    .cmd_stop    (cmd_stop),
    .loop_en     (loop_en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sheet_hold  (sheet_hold),
    .beat_display(beat_display),
    .frame_idx   (frame_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Hard stop in case a scenario stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- behavioural model ----------------
  // m_state: 0 idle, 1 playing, 2 paused, 3 holding the final frame
  int              m_state   = 0;
  int              m_elapsed = 0;
  int              m_next    = 0;
  logic [KEYS-1:0] m_hold    = '0;
  logic [BEATS-1:0] m_beat   = '0;
  logic            m_done    = 1'b0;
  logic [KEYS-1:0] m_mem [DEPTH];

  function automatic logic [BEATS-1:0] beat_vec(input int idx);
    int b;
    b = (idx / FPB) % BEATS;
    return BEATS'(1 << (BEATS - 1 - b));
  endfunction

  task automatic model_clear();
    m_state   = 0;
    m_elapsed = 0;
    m_next    = 0;
    m_hold    = '0;
    m_beat    = '0;
  endtask

  task automatic model_step(input logic play, input logic pause, input logic stop,
                            input logic loop, input logic wr,
                            input logic [AW-1:0] addr, input logic [KEYS-1:0] data);
    m_done = 1'b0;
    case (m_state)
      0: begin
        if (wr) m_mem[addr] = data;
        if (play && !stop) begin
          m_state   = 1;
          m_elapsed = 0;
        end
      end
      1: begin
        if (stop) model_clear();
        else if (pause) m_state = 2;
        else begin
          m_elapsed++;
          if (m_elapsed == TP) begin
            m_elapsed = 0;
            m_hold    = m_mem[m_next];
            m_beat    = beat_vec(m_next);
            if (m_next == DEPTH - 1) begin
              if (loop) m_next = 0;
              else m_state = 3;
            end else begin
              m_next++;
            end
          end
        end
      end
      2: begin
        if (stop) model_clear();
        else if (!pause && play) m_state = 1;
      end
      default: begin
        if (stop) model_clear();
        else begin
          m_elapsed++;
          if (m_elapsed == TP) begin
            model_clear();
            m_done = 1'b1;
          end
        end
      end
    endcase
  endtask

  function automatic logic [W-1:0] exp_pack();
    return {m_hold, m_beat, AW'(m_next), (m_state != 0), m_done};
  endfunction

  function automatic logic [W-1:0] obs_pack();
    return {sheet_hold, beat_display, frame_idx, busy, done};
  endfunction

  // One clock of stimulus: inputs change 1 ns after the edge, model follows the edge
  task automatic drive_cycle(input logic play, input logic pause, input logic stop,
                             input logic wr, input logic [AW-1:0] addr,
                             input logic [KEYS-1:0] data);
    cmd_play  = play;
    cmd_pause = pause;
    cmd_stop  = stop;
    wr_en     = wr;
    wr_addr   = addr;
    wr_data   = data;
    @(posedge clk_100mhz);
    model_step(play, pause, stop, loop_en, wr, addr, data);
    #1;
    cmd_play  = 1'b0;
    cmd_pause = 1'b0;
    cmd_stop  = 1'b0;
    wr_en     = 1'b0;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- scenarios ----------------
  logic [KEYS-1:0]  sheet_vals [DEPTH] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [BEATS-1:0] beat_vals  [DEPTH] = '{3'b100, 3'b100, 3'b010, 3'b010};

  task automatic test_reset();
    #12;
    if (obs_pack() !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got %h want %h", obs_pack(), {W{1'b0}});
    end
    n_vec++;
    @(posedge clk_100mhz);
    #1;
    rst_n = 1'b1;
    model_clear();
    m_done = 1'b0;
  endtask

  task automatic test_load();
    for (int k = 0; k < DEPTH; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, AW'(k), sheet_vals[k]);
      if (obs_pack() !== exp_pack()) begin
        n_bad++;
        $display("[TB] FAIL load_model k=%0d: got %h want %h", k, obs_pack(), exp_pack());
      end
      n_vec++;
    end
  endtask

  task automatic test_oneshot();
    loop_en = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 22; i++) begin
      idle_cycle();
      if (obs_pack() !== exp_pack()) begin
        n_bad++;
        $display("[TB] FAIL oneshot_model cyc=%0d: got %h want %h", i, obs_pack(), exp_pack());
      end
      n_vec++;
      if ((i % TP == 0) && (i <= 16)) begin
        if (sheet_hold !== sheet_vals[i/TP-1] || beat_display !== beat_vals[i/TP-1]) begin
          n_bad++;
          $display("[TB] FAIL oneshot_frame cyc=%0d: got %h/%b want %h/%b", i, sheet_hold,
                   beat_display, sheet_vals[i/TP-1], beat_vals[i/TP-1]);
        end
        n_vec++;
      end
      if (i == 20 || i == 21) begin
        if ({done, busy, sheet_hold, beat_display} !== {(i == 20), 1'b0, 8'h00, 3'b000}) begin
          n_bad++;
          $display("[TB] FAIL oneshot_done cyc=%0d: got done=%b busy=%b hold=%h beat=%b",
                   i, done, busy, sheet_hold, beat_display);
        end
        n_vec++;
      end
    end
  endtask

  task automatic test_loop();
    loop_en = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 26; i++) begin
      idle_cycle();
      if (obs_pack() !== exp_pack()) begin
        n_bad++;
        $display("[TB] FAIL loop_model cyc=%0d: got %h want %h", i, obs_pack(), exp_pack());
      end
      n_vec++;
      if (i == 20) begin
        if ({sheet_hold, beat_display, busy} !== {8'h01, 3'b100, 1'b1}) begin
          n_bad++;
          $display("[TB] FAIL loop_wrap: got hold=%h beat=%b busy=%b want 01/100/1",
                   sheet_hold, beat_display, busy);
        end
        n_vec++;
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    loop_en = 1'b0;
    idle_cycle();
  endtask

  task automatic test_pause();
    int waited;
    loop_en = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 9; i++) idle_cycle();
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      idle_cycle();
      if (obs_pack() !== exp_pack() || sheet_hold !== 8'h02) begin
        n_bad++;
        $display("[TB] FAIL pause_hold cyc=%0d: got %h want %h (hold 02)", i, obs_pack(), exp_pack());
      end
      n_vec++;
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    waited = -1;
    for (int i = 1; i <= 8 && waited < 0; i++) begin
      idle_cycle();
      if (obs_pack() !== exp_pack()) begin
        n_bad++;
        $display("[TB] FAIL resume_model cyc=%0d: got %h want %h", i, obs_pack(), exp_pack());
      end
      n_vec++;
      if (sheet_hold === 8'h04) waited = i;
    end
    if (waited != 3) begin
      n_bad++;
      $display("[TB] FAIL resume_latency: got %0d cycles want 3", waited);
    end
    n_vec++;
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    idle_cycle();
  endtask

  task automatic test_stop_play();
    loop_en = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) idle_cycle();
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    if (obs_pack() !== '0 || exp_pack() !== '0) begin
      n_bad++;
      $display("[TB] FAIL stop_play: got %h want %h", obs_pack(), {W{1'b0}});
    end
    n_vec++;
    idle_cycle();
    if (obs_pack() !== exp_pack()) begin
      n_bad++;
      $display("[TB] FAIL stop_settle: got %h want %h", obs_pack(), exp_pack());
    end
    n_vec++;
  endtask

  task automatic test_write_in_play();
    loop_en = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 22; i++) begin
      if (i == 2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'hFF);
      else idle_cycle();
      if (obs_pack() !== exp_pack()) begin
        n_bad++;
        $display("[TB] FAIL wrplay_model cyc=%0d: got %h want %h", i, obs_pack(), exp_pack());
      end
      n_vec++;
      if (i == 12 && sheet_hold !== 8'h04) begin
        n_bad++;
        $display("[TB] FAIL wrplay_ignored: got %h want 04", sheet_hold);
      end
      if (i == 12) n_vec++;
    end
  endtask

  task automatic test_reset_mid_play();
    loop_en = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) idle_cycle();
    #3;
    rst_n = 1'b0;
    #1;
    if (obs_pack() !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_async: got %h want %h", obs_pack(), {W{1'b0}});
    end
    n_vec++;
    model_clear();
    m_done = 1'b0;
    @(posedge clk_100mhz);
    #1;
    rst_n = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 22; i++) begin
      idle_cycle();
      if (obs_pack() !== exp_pack()) begin
        n_bad++;
        $display("[TB] FAIL replay_model cyc=%0d: got %h want %h", i, obs_pack(), exp_pack());
      end
      n_vec++;
      if (i == 4) begin
        if ({sheet_hold, beat_display} !== {8'h01, 3'b100}) begin
          n_bad++;
          $display("[TB] FAIL replay_first: got %h/%b want 01/100", sheet_hold, beat_display);
        end
        n_vec++;
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r == 6) loop_en = 1'($urandom_range(0, 1));
      if (r < 3)       drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      else if (r < 5)  drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      else if (r < 6)  drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      else if (r < 10) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, AW'($urandom_range(0, DEPTH - 1)),
                                   KEYS'($urandom));
      else             idle_cycle();
      if (obs_pack() !== exp_pack()) begin
        n_bad++;
        $display("[TB] FAIL random_model cyc=%0d: got %h want %h", i, obs_pack(), exp_pack());
      end
      n_vec++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_oneshot();
    test_loop();
    test_pause();
    test_stop_play();
    test_write_in_play();
    test_reset_mid_play();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
